// File: rtl/alu_pkg.sv
// Shared types, opcodes and default widths for the ALU issue/capture slice.
package alu_pkg;

  localparam int DW = 4;
  localparam int SW = 4;
  localparam int OW = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [SW-1:0] OP_ADD  = 4'b0000;
  localparam logic [SW-1:0] OP_SUB  = 4'b0001;
  localparam logic [SW-1:0] OP_MUL  = 4'b0010;
  localparam logic [SW-1:0] OP_DIV  = 4'b0011;
  localparam logic [SW-1:0] OP_SHL  = 4'b0100;
  localparam logic [SW-1:0] OP_SHR  = 4'b0101;
  localparam logic [SW-1:0] OP_ROL  = 4'b0110;
  localparam logic [SW-1:0] OP_ROR  = 4'b0111;
  localparam logic [SW-1:0] OP_AND  = 4'b1000;
  localparam logic [SW-1:0] OP_OR   = 4'b1001;
  localparam logic [SW-1:0] OP_XOR  = 4'b1010;
  localparam logic [SW-1:0] OP_NOR  = 4'b1011;
  localparam logic [SW-1:0] OP_NAND = 4'b1100;
  localparam logic [SW-1:0] OP_XNOR = 4'b1101;
  localparam logic [SW-1:0] OP_GT   = 4'b1110;
  localparam logic [SW-1:0] OP_EQ   = 4'b1111;

  function automatic logic is_div0(input logic [SW-1:0] sel, input logic [DW-1:0] b);
    return (sel == OP_DIV) && (b == {DW{1'b0}});
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Command, ALU-drive and result handshake bundle of the ALU issue stage.
interface alu_issue_stage_if import alu_pkg::*; #(parameter int TW = 8);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic [SW-1:0] cmd_sel;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [SW-1:0] alu_sel;
  logic [OW-1:0] alu_out;
  logic          res_valid;
  logic          res_ready;
  logic [OW-1:0] res_data;
  logic [TW-1:0] res_tag;
  logic          res_err;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_tag, res_err
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_tag, res_err
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO; the extra pointer bit separates full from empty, and a write is
// only visible at the head from the following edge.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign dout  = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; both wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push && !full) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (pop && !empty) rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push && !full) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/capture stage around the combinational ALU: FIFO -> operand regs -> result reg.
// Optional ALU_DIV0_CHECK_EN forces res_data=0 and res_err=1 on divide by zero.
module alu_issue_stage import alu_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int TW    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_stage_if.slave   bus
);

  localparam int PW = 2*DW + SW;

  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [PW-1:0] din_s;
  logic [PW-1:0] dout_s;
  logic          div0_s;
  logic [OW-1:0] cap_data_s;
  state_e        state_r;
  state_e        next_state_s;
  logic [DW-1:0] alu_a_r;
  logic [DW-1:0] alu_b_r;
  logic [SW-1:0] alu_sel_r;
  logic          res_valid_r;
  logic [OW-1:0] res_data_r;
  logic [TW-1:0] res_tag_r;
  logic          res_err_r;
  logic [TW-1:0] tag_cnt_r;

  assign push_s        = bus.cmd_valid && !full_s;
  assign din_s         = {bus.cmd_a, bus.cmd_b, bus.cmd_sel};
  assign bus.cmd_ready = !full_s;
  assign bus.alu_a     = alu_a_r;
  assign bus.alu_b     = alu_b_r;
  assign bus.alu_sel   = alu_sel_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_tag   = res_tag_r;
  assign bus.res_err   = res_err_r;

  alu_cmd_fifo #(.DEPTH(DEPTH), .W(PW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (din_s),
    .dout  (dout_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Next-state and pop decision.
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          next_state_s = EXEC;
          pop_s        = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC: next_state_s = DONE;
      DONE: begin
        if (bus.res_ready) begin
          if (!empty_s) begin
            next_state_s = EXEC;
            pop_s        = 1'b1;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Value captured into the result register at the end of EXEC.
  always_comb begin
    div0_s = 1'b0;
`ifdef ALU_DIV0_CHECK_EN
    div0_s = is_div0(alu_sel_r, alu_b_r);
`endif
    if (div0_s) begin
      cap_data_s = {OW{1'b0}};
    end else begin
      cap_data_s = bus.alu_out;
    end
  end

  // State, ALU operand, result and tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      alu_a_r     <= {DW{1'b0}};
      alu_b_r     <= {DW{1'b0}};
      alu_sel_r   <= {SW{1'b0}};
      res_valid_r <= 1'b0;
      res_data_r  <= {OW{1'b0}};
      res_tag_r   <= {TW{1'b0}};
      res_err_r   <= 1'b0;
      tag_cnt_r   <= {TW{1'b0}};
    end else begin
      state_r     <= next_state_s;
      res_valid_r <= (next_state_s == DONE);
      if (pop_s) {alu_a_r, alu_b_r, alu_sel_r} <= dout_s;
      if (state_r == EXEC) begin
        res_data_r <= cap_data_s;
        res_tag_r  <= tag_cnt_r;
        res_err_r  <= div0_s;
        tag_cnt_r  <= tag_cnt_r + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed + randomized bench for alu_issue_stage with an in-order result scoreboard.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TW    = 8;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  logic clk;
  logic rst_n;

  alu_issue_stage_if #(.TW(TW)) bus();

  alu_issue_stage #(.DEPTH(DEPTH), .TW(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [SW-1:0] s);
    case (s)
      OP_ADD:  return OW'(a) + OW'(b);
      OP_SUB:  return OW'(a) - OW'(b);
      OP_MUL:  return OW'(a) * OW'(b);
      OP_DIV:  return (b == 4'd0) ? 7'd0 : OW'(a / b);
      OP_SHL:  return OW'(a) << 1;
      OP_SHR:  return OW'(a >> 1);
      OP_ROL:  return OW'({a[2:0], a[3]});
      OP_ROR:  return OW'({a[0], a[3:1]});
      OP_AND:  return OW'(a & b);
      OP_OR:   return OW'(a | b);
      OP_XOR:  return OW'(a ^ b);
      OP_NOR:  return OW'(~(a | b));
      OP_NAND: return OW'(~(a & b));
      OP_XNOR: return OW'(~(a ^ b));
      OP_GT:   return OW'(a > b);
      OP_EQ:   return OW'(a == b);
      default: return 7'd0;
    endcase
  endfunction

  // Stand-in for the external combinational ALU.
  always_comb bus.alu_out = alu_ref(bus.alu_a, bus.alu_b, bus.alu_sel);

  exp_t          exp_q[$];
  logic [OW-1:0] log_data[$];
  logic [TW-1:0] log_tag[$];
  logic          log_err[$];
  int            log_cyc[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int model_tag = 0;
  int n_acc = 0;
  int bp_acc = 0;
  bit last_push = 1'b0;
  bit hold_v = 1'b0;
  bit wrapped = 1'b0;
  bit seen_any = 1'b0;
  logic [TW-1:0] last_tag;
  logic [OW-1:0] hold_d;
  logic [TW-1:0] hold_t;
  logic          hold_e;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  function automatic exp_t expect_for(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                      input logic [SW-1:0] s, input int tag);
    exp_t e;
    e.data = alu_ref(a, b, s);
    e.tag  = TW'(tag);
    e.err  = 1'b0;
`ifdef ALU_DIV0_CHECK_EN
    if (s == OP_DIV && b == 4'd0) begin
      e.data = 7'd0;
      e.err  = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic clear_log();
    log_data.delete();
    log_tag.delete();
    log_err.delete();
    log_cyc.delete();
  endtask

  // One clock: observe before the edge, update the scoreboard, return #1 after the edge.
  task automatic tick();
    bit   do_push;
    bit   do_acc;
    exp_t e;
    @(negedge clk);
    do_push = bus.cmd_valid && bus.cmd_ready;
    do_acc  = bus.res_valid && bus.res_ready;
    if (hold_v) begin
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_data", 32'(bus.res_data), 32'(hold_d));
      chk("hold_tag", 32'(bus.res_tag), 32'(hold_t));
      chk("hold_err", 32'(bus.res_err), 32'(hold_e));
    end
    hold_v = bus.res_valid && !bus.res_ready;
    hold_d = bus.res_data;
    hold_t = bus.res_tag;
    hold_e = bus.res_err;
    if (do_acc) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(bus.res_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", 32'(bus.res_data), 32'(e.data));
        chk("res_tag", 32'(bus.res_tag), 32'(e.tag));
        chk("res_err", 32'(bus.res_err), 32'(e.err));
        log_data.push_back(bus.res_data);
        log_tag.push_back(bus.res_tag);
        log_err.push_back(bus.res_err);
        log_cyc.push_back(cyc);
        if (seen_any && last_tag == 8'd255 && bus.res_tag == 8'd0) wrapped = 1'b1;
        last_tag = bus.res_tag;
        seen_any = 1'b1;
        n_acc++;
      end
    end
    if (do_push) begin
      exp_q.push_back(expect_for(bus.cmd_a, bus.cmd_b, bus.cmd_sel, model_tag));
      model_tag = (model_tag + 1) % (1 << TW);
    end
    last_push = do_push;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [SW-1:0] s);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = s;
    last_push     = 1'b0;
    for (int i = 0; i < 64 && !last_push; i++) tick();
    if (!last_push) chk("push_timeout", 32'(last_push), 32'd1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.res_valid); i++) tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 4'd0;
    bus.cmd_b     = 4'd0;
    bus.cmd_sel   = 4'd0;
    bus.res_ready = 1'b0;
    rst_n         = 1'b1;
    #1 rst_n      = 1'b0;
    #11;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_res_tag", 32'(bus.res_tag), 32'd0);
    chk("rst_res_err", 32'(bus.res_err), 32'd0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single add with latency check
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 4'd4;
    bus.cmd_b     = 4'd15;
    bus.cmd_sel   = OP_ADD;
    tick();
    bus.cmd_valid = 1'b0;
    chk("add_pushed", 32'(last_push), 32'd1);
    chk("add_k_valid", 32'(bus.res_valid), 32'd0);
    tick();
    chk("add_k1_alu_a", 32'(bus.alu_a), 32'd4);
    chk("add_k1_alu_b", 32'(bus.alu_b), 32'd15);
    chk("add_k1_alu_sel", 32'(bus.alu_sel), 32'd0);
    chk("add_k1_valid", 32'(bus.res_valid), 32'd0);
    tick();
    chk("add_k2_valid", 32'(bus.res_valid), 32'd1);
    chk("add_k2_data", 32'(bus.res_data), 32'd19);
    chk("add_k2_tag", 32'(bus.res_tag), 32'd0);
    chk("add_k2_err", 32'(bus.res_err), 32'd0);
    drain();

    // Back-to-back sub, mul, div
    clear_log();
    bus.res_ready = 1'b1;
    push_cmd(4'd4, 4'd15, OP_SUB);
    push_cmd(4'd4, 4'd15, OP_MUL);
    push_cmd(4'd4, 4'd15, OP_DIV);
    drain();
    chk("b2b_count", 32'(log_data.size()), 32'd3);
    if (log_data.size() == 3) begin
      chk("b2b_sub", 32'(log_data[0]), 32'd117);
      chk("b2b_mul", 32'(log_data[1]), 32'd60);
      chk("b2b_div", 32'(log_data[2]), 32'd0);
      chk("b2b_tag0", 32'(log_tag[0]), 32'd1);
      chk("b2b_tag2", 32'(log_tag[2]), 32'd3);
      chk("b2b_gap01", 32'(log_cyc[1] - log_cyc[0]), 32'd2);
      chk("b2b_gap12", 32'(log_cyc[2] - log_cyc[1]), 32'd2);
    end

    // Backpressure: one command in the result path plus DEPTH in the FIFO
    clear_log();
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bp_acc = 0;
    for (int i = 0; i < 12; i++) begin
      bus.cmd_a   = 4'($urandom);
      bus.cmd_b   = 4'($urandom);
      bus.cmd_sel = 4'($urandom);
      tick();
      if (last_push) bp_acc++;
    end
    chk("bp_accepted", 32'(bp_acc), 32'(DEPTH + 1));
    chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("bp_valid", 32'(bus.res_valid), 32'd1);
    bus.cmd_valid = 1'b0;
    drain();
    chk("bp_drained", 32'(log_data.size()), 32'(DEPTH + 1));

    // Rotate left
    clear_log();
    push_cmd(4'b1001, 4'($urandom), OP_ROL);
    drain();
    chk("rol_data", 32'(log_data[0]), 32'd3);

    // Divide by zero
    clear_log();
    push_cmd(4'd9, 4'd0, OP_DIV);
    drain();
`ifdef ALU_DIV0_CHECK_EN
    chk("div0_data", 32'(log_data[0]), 32'd0);
    chk("div0_err", 32'(log_err[0]), 32'd1);
`else
    chk("div0_err", 32'(log_err[0]), 32'd0);
`endif

    // Random traffic, long enough for the tag to wrap
    for (int i = 0; i < 900; i++) begin
      bus.cmd_valid = ($urandom_range(3) != 0);
      bus.cmd_a     = 4'($urandom);
      bus.cmd_b     = 4'($urandom);
      bus.cmd_sel   = 4'($urandom);
      bus.res_ready = ($urandom_range(3) != 0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    drain();
    chk("tag_wrapped", 32'(wrapped), 32'd1);

    // Asynchronous reset while in EXEC with two commands buffered
    bus.res_ready = 1'b1;
    push_cmd(4'd1, 4'd2, OP_ADD);
    push_cmd(4'd3, 4'd4, OP_MUL);
    push_cmd(4'd5, 4'd6, OP_XOR);
    push_cmd(4'd7, 4'd8, OP_SUB);
    chk("pre_rst_exec_valid", 32'(bus.res_valid), 32'd0);
    chk("pre_rst_alu_a", 32'(bus.alu_a), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mid_rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("mid_rst_alu_b", 32'(bus.alu_b), 32'd0);
    chk("mid_rst_alu_sel", 32'(bus.alu_sel), 32'd0);
    chk("mid_rst_tag", 32'(bus.res_tag), 32'd0);
    exp_q.delete();
    model_tag = 0;
    hold_v    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    push_cmd(4'd3, 4'd5, OP_ADD);
    drain();
    chk("post_rst_tag", 32'(log_tag[0]), 32'd0);
    chk("post_rst_data", 32'(log_data[0]), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
